// File: rtl/t05_cb_sram_sched_if.sv
// SRAM word-bus bundle used by the codebook SRAM scheduler.
// The scheduler drives the request side; the memory returns ack and read data.
interface t05_cb_sram_sched_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_sel,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_sel,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/t05_cb_sram_sched.sv
// Codebook SRAM port scheduler: round-robin between 3-word htree element reads and
// 4-word codebook path writes, with a per-word ack timeout and sticky error.
module t05_cb_sram_sched #(
    parameter logic [31:0] HTREE_BASE = 32'h3300_0000,
    parameter logic [31:0] CB_BASE    = 32'h3300_0400,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 curr_process,
    input  logic                       rd_req,
    input  logic [6:0]                 rd_index,
    input  logic                       wr_req,
    input  logic [7:0]                 wr_index,
    input  logic [127:0]               wr_path,
    t05_cb_sram_sched_if.master        mem,
    output logic [70:0]                h_element,
    output logic                       rd_valid,
    output logic                       wr_done,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [3:0]  CB_PHASE  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_XFER = 2'd1,
        WR_XFER = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [31:0] rd_addr(input logic [6:0] idx, input logic [1:0] k);
        rd_addr = HTREE_BASE + ((32'(idx) * 32'd3) + 32'(k)) * 32'd4;
    endfunction

    function automatic logic [31:0] wr_addr(input logic [7:0] idx, input logic [1:0] k);
        wr_addr = CB_BASE + (32'(idx) * 32'd16) + (32'(k) * 32'd4);
    endfunction

    state_t         state_r, state_n;
    logic [1:0]     k_r, k_n;
    logic [TW-1:0]  tmo_r, tmo_n;
    logic           gnt_rd_r, gnt_rd_n;
    logic           last_rd_r, last_rd_n;
    logic [6:0]     rd_idx_r, rd_idx_n;
    logic [7:0]     wr_idx_r, wr_idx_n;
    logic [127:0]   path_r, path_n;
    logic [70:0]    shadow_r, shadow_n;
    logic [70:0]    h_element_r, h_n;
    logic           err_r, err_n;

    logic           mem_req_r, mem_req_n;
    logic           mem_we_r, mem_we_n;
    logic [31:0]    mem_addr_r, mem_addr_n;
    logic [31:0]    mem_wdata_r, mem_wdata_n;
    logic [3:0]     mem_sel_r, mem_sel_n;
    logic           rd_valid_r, rd_valid_n;
    logic           wr_done_r, wr_done_n;
    logic           busy_r, busy_n;

    logic           ack_s;
    logic           grant_s;
    logic           pick_rd_s;
    logic           last_word_s;
    logic [TW-1:0]  tmo_inc_s;

    // An ack only counts while this block is actually requesting
    assign ack_s       = mem.mem_ack & mem_req_r;
    assign grant_s     = (curr_process == CB_PHASE) & (rd_req | wr_req);
    assign pick_rd_s   = rd_req & (~wr_req | ~last_rd_r);
    assign last_word_s = (state_r == RD_XFER) ? (k_r == 2'd2) : (k_r == 2'd3);
    assign tmo_inc_s   = tmo_r + TW'(1);

    // Next-state logic, word/timeout counters and request latches
    always_comb begin
        state_n   = state_r;
        k_n       = k_r;
        tmo_n     = tmo_r;
        gnt_rd_n  = gnt_rd_r;
        last_rd_n = last_rd_r;
        rd_idx_n  = rd_idx_r;
        wr_idx_n  = wr_idx_r;
        path_n    = path_r;
        shadow_n  = shadow_r;
        h_n       = h_element_r;
        err_n     = err_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    gnt_rd_n  = pick_rd_s;
                    last_rd_n = pick_rd_s;
                    k_n       = 2'd0;
                    tmo_n     = '0;
                    if (pick_rd_s) begin
                        rd_idx_n = rd_index;
                        state_n  = RD_XFER;
                    end else begin
                        wr_idx_n = wr_index;
                        path_n   = wr_path;
                        state_n  = WR_XFER;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            RD_XFER, WR_XFER: begin
                if (ack_s) begin
                    tmo_n = '0;
                    if (state_r == RD_XFER) begin
                        case (k_r)
                            2'd0:    shadow_n[31:0]  = mem.mem_rdata;
                            2'd1:    shadow_n[63:32] = mem.mem_rdata;
                            default: shadow_n[70:64] = mem.mem_rdata[6:0];
                        endcase
                    end else begin
                        shadow_n = shadow_r;
                    end
                    if (last_word_s) begin
                        state_n = DONE;
                        if (state_r == RD_XFER) begin
                            h_n = {mem.mem_rdata[6:0], shadow_r[63:0]};
                        end else begin
                            h_n = h_element_r;
                        end
                    end else begin
                        k_n = k_r + 2'd1;
                    end
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    // Abort: h_element keeps its previous value on a read timeout
                    tmo_n   = tmo_inc_s;
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    tmo_n = tmo_inc_s;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so registered outputs align with it
    always_comb begin
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = 32'd0;
        mem_wdata_n = 32'd0;
        case (state_n)
            RD_XFER: begin
                mem_req_n  = 1'b1;
                mem_addr_n = rd_addr(rd_idx_n, k_n);
            end
            WR_XFER: begin
                mem_req_n   = 1'b1;
                mem_we_n    = 1'b1;
                mem_addr_n  = wr_addr(wr_idx_n, k_n);
                mem_wdata_n = path_n[{k_n, 5'd0} +: 32];
            end
            default: begin
                mem_req_n = 1'b0;
            end
        endcase
        mem_sel_n  = mem_req_n ? 4'hF : 4'h0;
        rd_valid_n = (state_n == DONE) & gnt_rd_n;
        wr_done_n  = (state_n == DONE) & ~gnt_rd_n;
        busy_n     = (state_n != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            k_r         <= 2'd0;
            tmo_r       <= '0;
            gnt_rd_r    <= 1'b0;
            last_rd_r   <= 1'b0;
            rd_idx_r    <= 7'd0;
            wr_idx_r    <= 8'd0;
            path_r      <= 128'd0;
            shadow_r    <= 71'd0;
            h_element_r <= 71'd0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_sel_r   <= 4'h0;
            rd_valid_r  <= 1'b0;
            wr_done_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            k_r         <= k_n;
            tmo_r       <= tmo_n;
            gnt_rd_r    <= gnt_rd_n;
            last_rd_r   <= last_rd_n;
            rd_idx_r    <= rd_idx_n;
            wr_idx_r    <= wr_idx_n;
            path_r      <= path_n;
            shadow_r    <= shadow_n;
            h_element_r <= h_n;
            err_r       <= err_n;
            mem_req_r   <= mem_req_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
            mem_sel_r   <= mem_sel_n;
            rd_valid_r  <= rd_valid_n;
            wr_done_r   <= wr_done_n;
            busy_r      <= busy_n;
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_sel   = mem_sel_r;
    assign h_element     = h_element_r;
    assign rd_valid      = rd_valid_r;
    assign wr_done       = wr_done_r;
    assign busy          = busy_r;
    assign err           = err_r;

endmodule

// File: tb/tb_t05_cb_sram_sched.sv
// Self-checking bench for t05_cb_sram_sched: SRAM responder with programmable wait
// states, transfer log, and a reference model of addresses, data and latencies.
module tb_t05_cb_sram_sched;
    localparam logic [31:0] HTREE_BASE = 32'h3300_0000;
    localparam logic [31:0] CB_BASE    = 32'h3300_0400;
    localparam int          TMO        = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   curr_process = 4'd0;
    logic         rd_req = 1'b0;
    logic [6:0]   rd_index = 7'd0;
    logic         wr_req = 1'b0;
    logic [7:0]   wr_index = 8'd0;
    logic [127:0] wr_path = 128'd0;
    logic [70:0]  h_element;
    logic         rd_valid, wr_done, busy, err;

    t05_cb_sram_sched_if bus ();

    t05_cb_sram_sched dut (
        .clk          (clk),
        .rst          (rst),
        .curr_process (curr_process),
        .rd_req       (rd_req),
        .rd_index     (rd_index),
        .wr_req       (wr_req),
        .wr_index     (wr_index),
        .wr_path      (wr_path),
        .mem          (bus),
        .h_element    (h_element),
        .rd_valid     (rd_valid),
        .wr_done      (wr_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int req_cycles = 0, stab_err = 0, wcnt = 0, ack_delay = 0;
    bit no_ack = 1'b0;
    logic [31:0] held_addr = 32'd0;
    logic [70:0] h_model = 71'd0;
    logic [31:0] t_addr[$], t_wdata[$], t_rdata[$], rdata_q[$];
    bit          t_we[$];
    int          t_cyc[$], rv_cyc[$], wd_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM responder: acks after ack_delay waiting cycles, logs every accepted word
    always @(negedge clk) begin : responder
        logic [31:0] d;
        if (rd_valid) rv_cyc.push_back(cyc);
        if (wr_done)  wd_cyc.push_back(cyc);
        if (bus.mem_req) begin
            req_cycles++;
            if (wcnt > 0 && bus.mem_addr !== held_addr) stab_err++;
            if (bus.mem_sel !== 4'hF) stab_err++;
            held_addr = bus.mem_addr;
        end
        if (bus.mem_req && !no_ack && wcnt >= ack_delay) begin
            if (rdata_q.size() > 0) d = rdata_q.pop_front();
            else d = $urandom;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = d;
            t_addr.push_back(bus.mem_addr);
            t_we.push_back(bus.mem_we);
            t_wdata.push_back(bus.mem_wdata);
            t_rdata.push_back(d);
            t_cyc.push_back(cyc);
            wcnt = 0;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req) wcnt++;
            else wcnt = 0;
        end
    end

    function automatic logic [31:0] exp_rd_addr(input int idx, input int k);
        exp_rd_addr = HTREE_BASE + 32'((idx * 3 + k) * 4);
    endfunction

    function automatic logic [31:0] exp_wr_addr(input int idx, input int k);
        exp_wr_addr = CB_BASE + 32'(idx * 16 + k * 4);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        t_addr.delete(); t_we.delete(); t_wdata.delete(); t_rdata.delete(); t_cyc.delete();
        rv_cyc.delete(); wd_cyc.delete();
        req_cycles = 0;
        stab_err = 0;
    endtask

    // Raise one request in an IDLE cycle (t0) and hold it until its completion pulse
    task automatic issue(input bit is_rd, input int idx, input logic [127:0] path,
                         input int budget, output bit ok, output int t0);
        step();
        clear_logs();
        if (is_rd) begin
            rd_index = 7'(idx);
            rd_req   = 1'b1;
        end else begin
            wr_index = 8'(idx);
            wr_path  = path;
            wr_req   = 1'b1;
        end
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (is_rd ? rd_valid : wr_done) begin
                ok = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.mem_req, bus.mem_we, busy, err, rd_valid, wr_done} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.mem_req, bus.mem_we, busy, err, rd_valid, wr_done});
        end
        checks++;
        if (h_element !== 71'd0 || bus.mem_sel !== 4'h0 || bus.mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: h=%h sel=%h addr=%h want all 0", h_element, bus.mem_sel, bus.mem_addr);
        end
        rst = 1'b1;
        curr_process = 4'b0100;
        step();
    endtask

    task automatic test_read_basic();
        bit ok; int t0;
        logic [70:0] exp;
        rdata_q = '{32'h1111_1111, 32'h2222_2222, 32'hFFFF_FF85};
        issue(1'b1, 5, 128'd0, 20, ok, t0);
        exp = {7'h05, 32'h2222_2222, 32'h1111_1111};
        checks++;
        if (!ok || rv_cyc.size() != 1 || rv_cyc[0] != t0 + 4) begin
            errors++;
            $display("FAIL read_latency: got ok=%0d n=%0d at %0d want cycle %0d", ok, rv_cyc.size(),
                     (rv_cyc.size() > 0) ? rv_cyc[0] - t0 : -1, 4);
        end
        checks++;
        if (t_addr.size() != 3 || t_addr[0] !== 32'h3300_003C || t_addr[1] !== 32'h3300_0040 ||
            t_addr[2] !== 32'h3300_0044 || t_we[0] || t_we[2]) begin
            errors++;
            $display("FAIL read_addr: n=%0d a0=%h a2=%h want 3 words 3300003c..33000044 reads",
                     t_addr.size(), t_addr[0], t_addr[2]);
        end
        checks++;
        if (h_element !== exp) begin
            errors++;
            $display("FAIL read_element: got %h want %h", h_element, exp);
        end
        h_model = exp;
        step();
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse_width: rd_valid=%b busy=%b want 0 0", rd_valid, busy);
        end
    endtask

    task automatic test_write_basic();
        bit ok; int t0;
        logic [127:0] p;
        p = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        issue(1'b0, 8'h41, p, 20, ok, t0);
        checks++;
        if (!ok || wd_cyc.size() != 1 || wd_cyc[0] != t0 + 5) begin
            errors++;
            $display("FAIL write_latency: got ok=%0d n=%0d want done at cycle 5", ok, wd_cyc.size());
        end
        checks++;
        if (t_addr.size() != 4) begin
            errors++;
            $display("FAIL write_count: got %0d want 4", t_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (t_addr[k] !== 32'h3300_0810 + 32'(k * 4) || !t_we[k] ||
                    t_wdata[k] !== p[32*k +: 32]) begin
                    errors++;
                    $display("FAIL write_word%0d: got %h/%h we=%0d want %h/%h", k, t_addr[k], t_wdata[k],
                             t_we[k], 32'h3300_0810 + 32'(k * 4), p[32*k +: 32]);
                end
            end
        end
        checks++;
        if (h_element !== h_model) begin
            errors++;
            $display("FAIL write_h_stable: got %h want %h", h_element, h_model);
        end
    endtask

    task automatic test_ack_delay();
        bit ok; int t0;
        ack_delay = 3;
        issue(1'b1, 17, 128'd0, 40, ok, t0);
        ack_delay = 0;
        checks++;
        if (!ok || rv_cyc.size() != 1 || rv_cyc[0] != t0 + 13) begin
            errors++;
            $display("FAIL delay_latency: got %0d want 13", (rv_cyc.size() > 0) ? rv_cyc[0] - t0 : -1);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL delay_addr_stable: got %0d changes want 0", stab_err);
        end
        if (t_rdata.size() == 3) h_model = {t_rdata[2][6:0], t_rdata[1], t_rdata[0]};
        checks++;
        if (h_element !== h_model || t_addr.size() != 3 || t_addr[1] !== exp_rd_addr(17, 1)) begin
            errors++;
            $display("FAIL delay_element: got %h want %h", h_element, h_model);
        end
    endtask

    task automatic test_process_gate();
        bit ok;
        step();
        clear_logs();
        curr_process = 4'b0011;
        rd_index = 7'd9;
        rd_req = 1'b1;
        repeat (5) step();
        checks++;
        if (req_cycles != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_blocked: got req_cycles=%0d busy=%b want 0 0", req_cycles, busy);
        end
        curr_process = 4'b0100;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_rd_addr(9, 0)) begin
            errors++;
            $display("FAIL gate_open: got req=%b addr=%h want 1 %h", bus.mem_req, bus.mem_addr, exp_rd_addr(9, 0));
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        if (t_rdata.size() == 3) h_model = {t_rdata[2][6:0], t_rdata[1], t_rdata[0]};
        checks++;
        if (!ok || h_element !== h_model) begin
            errors++;
            $display("FAIL gate_complete: ok=%0d h=%h want 1 %h", ok, h_element, h_model);
        end
    endtask

    task automatic test_random();
        bit ok, is_rd; int t0, idx, d, n;
        logic [127:0] p;
        for (int t = 0; t < 10; t++) begin
            is_rd = 1'($urandom_range(0, 1));
            idx   = is_rd ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 255));
            if (t == 0) idx = 127;
            if (t == 1) idx = 255;
            if (t == 1) is_rd = 1'b0;
            d     = int'($urandom_range(0, 2));
            p     = {$urandom, $urandom, $urandom, $urandom};
            n     = is_rd ? 3 : 4;
            ack_delay = d;
            issue(is_rd, idx, p, 60, ok, t0);
            ack_delay = 0;
            checks++;
            if (!ok || (is_rd ? rv_cyc.size() : wd_cyc.size()) != 1 ||
                (is_rd ? rv_cyc[0] : wd_cyc[0]) != t0 + n * (d + 1) + 1 || t_addr.size() != n) begin
                errors++;
                $display("FAIL rand%0d_done: ok=%0d words=%0d want done at %0d with %0d words",
                         t, ok, t_addr.size(), n * (d + 1) + 1, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (t_addr[k] !== (is_rd ? exp_rd_addr(idx, k) : exp_wr_addr(idx, k)) ||
                        t_we[k] !== !is_rd || t_cyc[k] != t0 + (k + 1) * (d + 1) ||
                        (!is_rd && t_wdata[k] !== p[32*k +: 32])) begin
                        errors++;
                        $display("FAIL rand%0d_word%0d: got %h we=%0d d=%h want %h", t, k, t_addr[k],
                                 t_we[k], t_wdata[k], is_rd ? exp_rd_addr(idx, k) : exp_wr_addr(idx, k));
                    end
                end
                if (is_rd) h_model = {t_rdata[2][6:0], t_rdata[1], t_rdata[0]};
            end
            checks++;
            if (h_element !== h_model) begin
                errors++;
                $display("FAIL rand%0d_element: got %h want %h", t, h_element, h_model);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; int t0;
        no_ack = 1'b1;
        issue(1'b1, 33, 128'd0, 300, ok, t0);
        no_ack = 1'b0;
        checks++;
        if (!ok || req_cycles != TMO) begin
            errors++;
            $display("FAIL timeout_abort: ok=%0d req_cycles=%0d want 1 %0d", ok, req_cycles, TMO);
        end
        checks++;
        if (err !== 1'b1 || h_element !== h_model || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: err=%b req=%b h=%h want 1 0 %h", err, bus.mem_req, h_element, h_model);
        end
        repeat (3) step();
        checks++;
        if (rv_cyc.size() != 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d pulses want 1", rv_cyc.size());
        end
        issue(1'b0, 7, {$urandom, $urandom, $urandom, $urandom}, 20, ok, t0);
        checks++;
        if (!ok || err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: ok=%0d err=%b want 1 1", ok, err);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        step();
        clear_logs();
        wr_index = 8'd3;
        wr_path  = {$urandom, $urandom, $urandom, $urandom};
        wr_req   = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (t_addr.size() == 3) begin
                hit = 1'b1;
                break;
            end
        end
        rst = 1'b0;
        wr_req = 1'b0;
        step();
        checks++;
        if (!hit || bus.mem_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hit=%0d req=%b busy=%b err=%b want 1 0 0 0", hit, bus.mem_req, busy, err);
        end
        rst = 1'b1;
        h_model = 71'd0;
        repeat (2) step();
        checks++;
        if (wd_cyc.size() != 0 || h_element !== h_model) begin
            errors++;
            $display("FAIL reset_mid_after: done=%0d h=%h want 0 0", wd_cyc.size(), h_element);
        end
    endtask

    task automatic test_back_to_back();
        int t0, ri, wi;
        bit ok;
        step();
        clear_logs();
        ri = int'($urandom_range(0, 127));
        wi = int'($urandom_range(0, 255));
        rd_index = 7'(ri);
        wr_index = 8'(wi);
        wr_path  = {$urandom, $urandom, $urandom, $urandom};
        rd_req = 1'b1;
        wr_req = 1'b1;
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rv_cyc.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        checks++;
        if (!ok || wd_cyc.size() != 1 || rv_cyc[0] != t0 + 4 || wd_cyc[0] != t0 + 10 ||
            rv_cyc[1] != t0 + 15) begin
            errors++;
            $display("FAIL b2b_order: ok=%0d rv0=%0d wd0=%0d rv1=%0d want 4 10 15", ok,
                     rv_cyc[0] - t0, wd_cyc[0] - t0, rv_cyc[1] - t0);
        end
        checks++;
        if (t_addr.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 10", t_addr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (t_addr[i] !== ((i >= 3 && i < 7) ? exp_wr_addr(wi, i - 3) :
                                   exp_rd_addr(ri, (i < 3) ? i : i - 7)) ||
                    t_we[i] !== (i >= 3 && i < 7)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h we=%0d", i, t_addr[i], t_we[i]);
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_ack_delay();
        test_process_gate();
        test_random();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/t05_cb_sram_sched.md
Name: t05_cb_sram_sched

Overview:
Schedules the single 32-bit SRAM bus port shared by codebook synthesis. It has two requesters:
- Read requester: fetches 71-bit htree elements by tree index.
- Write requester: stores 128-bit character paths by character index.

The block round-robin arbitrates between them and splits each request into word transfers with a req/ack handshake. It returns assembled elements and completion pulses, and flags a sticky error on ack timeout. It is only active during the codebook controller phase.

Parameters:
HTREE_BASE, 32'h3300_0000, byte address of htree element 0 (3 words per element).
CB_BASE, 32'h3300_0400, byte address of codebook entry 0 (4 words per entry).
TIMEOUT, 255, maximum cycles to wait for mem_ack on one word before aborting.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
curr_process  input  4  controller state; new grants only when 4'b0100
rd_req  input  1  htree element read request; level, held until rd_valid
rd_index  input  7  htree index to read
wr_req  input  1  codebook write request; level, held until wr_done
wr_index  input  8  character index to write
wr_path  input  128  character path to write
mem_rdata  input  32  SRAM read data, valid with mem_ack
mem_ack  input  1  SRAM word acknowledge; may be high in the same cycle as mem_req
mem_req  output  1  SRAM word request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  SRAM byte address
mem_wdata  output  32  SRAM write data
mem_sel  output  4  byte enables; always 4'hF while mem_req is high, else 0
h_element  output  71  last completed htree element
rd_valid  output  1  one-cycle read completion pulse
wr_done  output  1  one-cycle write completion pulse
busy  output  1  high in any state other than IDLE
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst low at posedge):
  - State IDLE; word counter, timeout counter and err cleared.
  - All outputs 0, h_element 0.
  - last_grant = WRITE, so the first simultaneous request goes to READ.
- States: IDLE, RD_XFER, WR_XFER, DONE.
- IDLE:
  - Grants only if curr_process == 4'b0100 and at least one request is high.
  - Only one request high: grant it.
  - Both high: grant the opposite of last_grant, then update last_grant.
  - At grant, latch rd_index, or wr_index and wr_path; clear word counter k and timeout counter.
  - Go to RD_XFER or WR_XFER.
- RD_XFER:
  - mem_req=1, mem_we=0, mem_addr = HTREE_BASE + (idx*3 + k)*4, for k = 0..2.
  - On mem_ack, capture into the shadow buffer: word0 -> [31:0], word1 -> [63:32], word2[6:0] -> [70:64]. Upper bits of word2 are ignored.
  - After ack on k=2: copy shadow to h_element and go to DONE.
- WR_XFER:
  - mem_req=1, mem_we=1, mem_addr = CB_BASE + wr_index*16 + k*4.
  - mem_wdata = path[32k+31:32k], for k = 0..3, ascending.
  - After ack on k=3: go to DONE.
- Address arithmetic is 32-bit unsigned, wrap-around modulo 2^32.
- mem_req stays high across consecutive words. Each ack advances k by exactly 1. Acks while mem_req is low are ignored.
- Timeout:
  - The counter increments each XFER cycle without ack and resets on ack.
  - When it reaches TIMEOUT: drop mem_req, set err=1 (sticky until reset), go to DONE.
  - On a read timeout, h_element is not updated.
- DONE (one cycle):
  - Pulse rd_valid or wr_done for the granted requester.
  - Requests are not sampled this cycle. The requester drops its req on seeing the pulse.
  - Return to IDLE.
- Latency with zero-wait acks:
  - Read: grant at cycle 0, words at cycles 1–3, rd_valid at cycle 4.
  - Write: grant at cycle 0, words at cycles 1–4, wr_done at cycle 5.
- Request deasserted mid-transfer: ignored; the transfer completes.
- curr_process leaves 4'b0100 mid-transfer: the transfer completes; no new grants are issued.
- Reset mid-transfer: immediate return to reset state; mem_req drops in the same cycle.

Test Plan:
- Read idx 5, zero-wait ack, rdata 0x11111111/0x22222222/0xFFFFFF85:
  - Addresses 0x3300_003C, 0x40, 0x44.
  - rd_valid at cycle 4; h_element = {7'h05, 0x22222222, 0x11111111}.
- Write idx 0x41, path = 128'h0123…CDEF:
  - Four writes at 0x3300_0810..0x81C, low word first.
  - wr_done at cycle 5.
- rd_req and wr_req high together from reset, both held:
  - Order is read, write, read.
  - No idle gap apart from the DONE and IDLE cycles.
- Ack delayed 3 cycles per word on a read:
  - mem_addr stable while waiting; rd_valid at cycle 13.
- No ack for TIMEOUT cycles:
  - mem_req drops, err=1, rd_valid pulses once, h_element unchanged.
  - err remains 1 through later successful transfers until rst is low.
- curr_process = 4'b0011 with rd_req high:
  - No mem_req.
  - Switch to 4'b0100: grant on the next cycle.
- rst low during WR_XFER k=2:
  - Next cycle: mem_req=0, busy=0, err=0.
